// File: rtl/vote_collector.sv
// Five-voter ballot front end: synchronises and debounces YES/NO buttons, runs the
// IDLE/OPEN/RESULT session and presents a frozen ballot to the tally decoder.
module vote_collector #(
   parameter logic [15:0] DEBOUNCE = 16'd50000,
   parameter logic [31:0] TIMEOUT  = 32'd500000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] yes_btn,
   input  logic [4:0] no_btn,
   input  logic       start,
   input  logic       close,
   output logic [4:0] comps,
   output logic [4:0] voted,
   output logic       open,
   output logic       done
);

   localparam int unsigned CntWidth = $clog2(32'(DEBOUNCE) + 1);
   localparam logic [CntWidth-1:0] CntLast = CntWidth'(DEBOUNCE - 16'd1);

   typedef enum logic [1:0] {StIdle, StOpen, StResult} state_e;

   // Lines 0..4 are YES buttons, 5..9 are NO buttons.
   logic [9:0]          raw;
   logic [9:0]          sync1_q;
   logic [9:0]          sync2_q;
   logic [9:0]          deb_q;
   logic [9:0]          evt_q;
   logic [CntWidth-1:0] cnt_q [10];
   logic [4:0]          yes_evt;
   logic [4:0]          no_evt;

   assign raw     = {no_btn, yes_btn};
   assign yes_evt = evt_q[4:0];
   assign no_evt  = evt_q[9:5];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         deb_q   <= '0;
         evt_q   <= '0;
         for (int i = 0; i < 10; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         evt_q   <= '0;
         for (int i = 0; i < 10; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CntLast) begin
               // Level flips here; the event pulse lines up with the new debounced level.
               cnt_q[i] <= '0;
               deb_q[i] <= sync2_q[i];
               evt_q[i] <= sync2_q[i];
            end else begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   state_e      state_q, state_d;
   logic [4:0]  ballot_q, ballot_d;
   logic [4:0]  voted_q, voted_d;
   logic [4:0]  comps_q, comps_d;
   logic [31:0] timer_q, timer_d;
   logic        open_q, open_d;
   logic        done_q, done_d;
   logic        timeout_hit;

   assign timeout_hit = (TIMEOUT != 32'd0) && (timer_q == TIMEOUT - 32'd1);

   always_comb begin
      state_d  = state_q;
      ballot_d = ballot_q;
      voted_d  = voted_q;
      comps_d  = comps_q;
      timer_d  = timer_q;
      open_d   = open_q;
      done_d   = done_q;
      unique case (state_q)
         StIdle: begin
            comps_d = '0;
            voted_d = '0;
            open_d  = 1'b0;
            done_d  = 1'b0;
            if (start) begin
               state_d  = StOpen;
               ballot_d = '0;
               timer_d  = '0;
               open_d   = 1'b1;
            end
         end
         StOpen: begin
            comps_d = '0;
            if (close || (voted_q == 5'b11111) || timeout_hit) begin
               // Any vote arriving on the exit cycle is dropped.
               state_d = StResult;
               comps_d = ballot_q;
               open_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               if (TIMEOUT != 32'd0) begin
                  timer_d = timer_q + 32'd1;
               end
               for (int i = 0; i < 5; i++) begin
                  if (!voted_q[i] && (yes_evt[i] ^ no_evt[i])) begin
                     voted_d[i]  = 1'b1;
                     ballot_d[i] = yes_evt[i];
                  end
               end
            end
         end
         StResult: begin
            if (start) begin
               state_d  = StOpen;
               ballot_d = '0;
               voted_d  = '0;
               timer_d  = '0;
               comps_d  = '0;
               open_d   = 1'b1;
               done_d   = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         ballot_q <= '0;
         voted_q  <= '0;
         comps_q  <= '0;
         timer_q  <= '0;
         open_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ballot_q <= ballot_d;
         voted_q  <= voted_d;
         comps_q  <= comps_d;
         timer_q  <= timer_d;
         open_q   <= open_d;
         done_q   <= done_d;
      end
   end

   assign comps = comps_q;
   assign voted = voted_q;
   assign open  = open_q;
   assign done  = done_q;

endmodule

// File: tb/tb_vote_collector.sv
// Directed bench for vote_collector: a step table on a DEBOUNCE=4/TIMEOUT=0 instance,
// plus a timeout sequence on a second instance with TIMEOUT=100.
module tb_vote_collector;

   logic       clk;
   logic       rst;
   logic [4:0] yes_btn;
   logic [4:0] no_btn;
   logic       start;
   logic       close;
   logic [4:0] comps, comps_t;
   logic [4:0] voted, voted_t;
   logic       open, open_t;
   logic       done, done_t;

   int n_cmp = 0;
   int n_bad = 0;

   vote_collector #(.DEBOUNCE(16'd4), .TIMEOUT(32'd0)) dut (
      .clk    (clk),
      .rst    (rst),
      .yes_btn(yes_btn),
      .no_btn (no_btn),
      .start  (start),
      .close  (close),
      .comps  (comps),
      .voted  (voted),
      .open   (open),
      .done   (done)
   );

   vote_collector #(.DEBOUNCE(16'd4), .TIMEOUT(32'd100)) dut_t (
      .clk    (clk),
      .rst    (rst),
      .yes_btn(yes_btn),
      .no_btn (no_btn),
      .start  (start),
      .close  (close),
      .comps  (comps_t),
      .voted  (voted_t),
      .open   (open_t),
      .done   (done_t)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       start;
      logic       close;
      logic [4:0] yes;
      logic [4:0] no;
      int         cyc;
      logic [4:0] ec;
      logic [4:0] ev;
      logic       eo;
      logic       ed;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic r, input logic s, input logic c, input logic [4:0] y,
                      input logic [4:0] n, input int cyc, input logic [4:0] ec,
                      input logic [4:0] ev, input logic eo, input logic ed);
      vec_t v;
      v.rst = r; v.start = s; v.close = c; v.yes = y; v.no = n; v.cyc = cyc;
      v.ec = ec; v.ev = ev; v.eo = eo; v.ed = ed;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input int idx, input logic [4:0] act,
                      input logic [4:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL vec%0d %s: got %b, want %b", idx, nm, act, exp);
      end
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; close = 1'b0; yes_btn = '0; no_btn = '0;

      //   rst   start close yes      no       cyc comps    voted    open  done
      add(1'b1, 1'b0, 1'b0, 5'b00000, 5'b00000, 2, 5'b00000, 5'b00000, 1'b0, 1'b0); // 0 reset
      add(1'b0, 1'b1, 1'b0, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 1'b1, 1'b0); // 1 start
      add(1'b0, 1'b0, 1'b0, 5'b10101, 5'b01010, 6, 5'b00000, 5'b00000, 1'b1, 1'b0); // 2 latency-1
      add(1'b0, 1'b0, 1'b0, 5'b10101, 5'b01010, 1, 5'b00000, 5'b11111, 1'b1, 1'b0); // 3 all in
      add(1'b0, 1'b0, 1'b0, 5'b10101, 5'b01010, 1, 5'b10101, 5'b11111, 1'b0, 1'b1); // 4 result
      add(1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 3, 5'b10101, 5'b11111, 1'b0, 1'b1); // 5 frozen
      add(1'b0, 1'b0, 1'b1, 5'b00000, 5'b00000, 1, 5'b10101, 5'b11111, 1'b0, 1'b1); // 6 close ign
      add(1'b0, 1'b1, 1'b0, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 1'b1, 1'b0); // 7 reopen
      add(1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 10, 5'b00000, 5'b00000, 1'b1, 1'b0); // 8 idle
      add(1'b0, 1'b0, 1'b0, 5'b00010, 5'b00000, 3, 5'b00000, 5'b00000, 1'b1, 1'b0); // 9 glitch
      add(1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 10, 5'b00000, 5'b00000, 1'b1, 1'b0); // 10
      add(1'b0, 1'b0, 1'b0, 5'b00010, 5'b00000, 6, 5'b00000, 5'b00000, 1'b1, 1'b0); // 11 press
      add(1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00010, 1'b1, 1'b0); // 12 +7
      add(1'b0, 1'b0, 1'b0, 5'b00100, 5'b00000, 7, 5'b00000, 5'b00110, 1'b1, 1'b0); // 13 v2 yes
      add(1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 10, 5'b00000, 5'b00110, 1'b1, 1'b0); // 14
      add(1'b0, 1'b0, 1'b0, 5'b00000, 5'b00100, 7, 5'b00000, 5'b00110, 1'b1, 1'b0); // 15 v2 no
      add(1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 10, 5'b00000, 5'b00110, 1'b1, 1'b0); // 16
      add(1'b0, 1'b0, 1'b0, 5'b01000, 5'b01000, 7, 5'b00000, 5'b00110, 1'b1, 1'b0); // 17 v3 both
      add(1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 10, 5'b00000, 5'b00110, 1'b1, 1'b0); // 18
      add(1'b0, 1'b0, 1'b0, 5'b00000, 5'b00001, 7, 5'b00000, 5'b00111, 1'b1, 1'b0); // 19 v0 no
      add(1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 10, 5'b00000, 5'b00111, 1'b1, 1'b0); // 20
      add(1'b0, 1'b0, 1'b0, 5'b10000, 5'b00000, 6, 5'b00000, 5'b00111, 1'b1, 1'b0); // 21 v4 yes
      add(1'b0, 1'b0, 1'b1, 5'b10000, 5'b00000, 1, 5'b00110, 5'b00111, 1'b0, 1'b1); // 22 close
      add(1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 3, 5'b00110, 5'b00111, 1'b0, 1'b1); // 23 frozen
      add(1'b0, 1'b1, 1'b0, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 1'b1, 1'b0); // 24 reopen
      add(1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 10, 5'b00000, 5'b00000, 1'b1, 1'b0); // 25
      add(1'b0, 1'b0, 1'b0, 5'b00001, 5'b00000, 7, 5'b00000, 5'b00001, 1'b1, 1'b0); // 26 v0 yes
      add(1'b1, 1'b0, 1'b0, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 1'b0, 1'b0); // 27 rst
      add(1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 2, 5'b00000, 5'b00000, 1'b0, 1'b0); // 28 idle
      add(1'b0, 1'b1, 1'b0, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 1'b1, 1'b0); // 29 start
      add(1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 10, 5'b00000, 5'b00000, 1'b1, 1'b0); // 30
      add(1'b0, 1'b0, 1'b0, 5'b00000, 5'b10000, 7, 5'b00000, 5'b10000, 1'b1, 1'b0); // 31 v4 no
      add(1'b0, 1'b1, 1'b0, 5'b00000, 5'b00000, 1, 5'b00000, 5'b10000, 1'b1, 1'b0); // 32 no rest.
      add(1'b0, 1'b1, 1'b1, 5'b00000, 5'b00000, 1, 5'b00000, 5'b10000, 1'b0, 1'b1); // 33 close

      @(negedge clk);
      foreach (vq[k]) begin
         rst = vq[k].rst; start = vq[k].start; close = vq[k].close;
         yes_btn = vq[k].yes; no_btn = vq[k].no;
         run(vq[k].cyc);
         chk("comps", k, comps, vq[k].ec);
         chk("voted", k, voted, vq[k].ev);
         chk("open", k, {4'b0, open}, {4'b0, vq[k].eo});
         chk("done", k, {4'b0, done}, {4'b0, vq[k].ed});
      end

      // Timeout: done rises exactly 100 OPEN cycles after the start edge.
      start = 1'b0; close = 1'b0; yes_btn = '0; no_btn = '0;
      rst = 1'b1;
      run(2);
      rst = 1'b0;
      start = 1'b1;
      run(1);
      start = 1'b0;
      chk("t_open_entry", 100, {4'b0, open_t}, 5'b00001);
      yes_btn = 5'b00001;
      run(7);
      chk("t_voted", 101, voted_t, 5'b00001);
      yes_btn = '0;
      run(92);
      chk("t_done_99", 102, {4'b0, done_t}, 5'b00000);
      chk("t_open_99", 102, {4'b0, open_t}, 5'b00001);
      run(1);
      chk("t_done_100", 103, {4'b0, done_t}, 5'b00001);
      chk("t_open_100", 103, {4'b0, open_t}, 5'b00000);
      chk("t_comps", 103, comps_t, 5'b00001);
      chk("t_voted_held", 103, voted_t, 5'b00001);
      // With TIMEOUT=0 the other instance is still collecting.
      chk("nt_open", 104, {4'b0, open}, 5'b00001);
      chk("nt_done", 104, {4'b0, done}, 5'b00000);
      chk("nt_voted", 104, voted, 5'b00001);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
